row_merge_sequencer: RTL
========================

ROW_MERGE_SEQUENCER -- requirements
Module: row_merge_sequencer

Interface
REQ-001 SHALL have port clock  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port req  in  1  move request, sampled only in IDLE.
REQ-004 SHALL have port dir  in  2  direction: 00 left, 01 right, 10 down, 11 up.
REQ-005 SHALL have port board_in  in  64  16 tiles x 4 bits, tile 0 at [63:60], row-major.
REQ-006 SHALL have port busy  out  1  high from the cycle after acceptance until done.
REQ-007 SHALL have port done  out  1  single-cycle pulse; board_out/moved valid.
REQ-008 SHALL have port board_out  out  64  moved board, held until next done.
REQ-009 SHALL have port moved  out  1  board_out differs from latched board_in.
REQ-010 SHALL have port score_delta  out  16  present only with SCORE_EN.

Function
REQ-011 Tile encoding SHALL be log2: 0 empty, v nonzero means 2^v; merging two tiles of v yields v+1, saturating at 15.
REQ-012 States SHALL be IDLE, LOAD, LANE, FINISH; no other reachable state.
REQ-013 IDLE with req=1 SHALL go to LOAD and latch board_in and dir that cycle; req=0 stays IDLE.
REQ-014 LOAD SHALL clear lane counter, moved and score accumulators, copy latched board into result register, go to LANE.
REQ-015 LANE SHALL process one lane per cycle through the single shared merge unit, lanes 0..3, then go to FINISH.
REQ-016 Lane k ordering (leading tile first): left = tiles 4k..4k+3; right = 4k+3..4k; up = k, k+4, k+8, k+12; down = k+12, k+8, k+4, k.
REQ-017 Merge unit SHALL compact nonzero tiles toward the leading end, merge equal adjacent pairs once each from the leading end, zero-fill trailing slots.
REQ-018 Merged lane SHALL be written back to the same tile positions in the result register that cycle; moved ORs the lane-changed flag.
REQ-019 FINISH SHALL drive board_out from result register, pulse done for exactly one cycle, return to IDLE.
REQ-020 Latency SHALL be fixed: req accepted at edge T gives done high in cycle T+6 (LOAD, 4xLANE, FINISH).
REQ-021 busy SHALL be low in IDLE and FINISH-exit, high in LOAD and LANE and FINISH.
REQ-022 req while busy SHALL be ignored, not queued; req held high in FINISH's following IDLE cycle starts a new move.
REQ-023 dir and board_in changes while busy SHALL have no effect on the current move.

Reset
REQ-024 reset_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, moved=0, board_out=0, score_delta=0, abandoning any move in progress with no done.

Configuration
REQ-025 Macro SCORE_EN defined: score_delta SHALL output sum of 2^(v+1) over all merges of the move, saturating at 16'hFFFF, valid with done.
REQ-026 SCORE_EN undefined: score_delta port, accumulator and merge-unit score logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Shared package SHALL hold tile width (4), tile count (16), lane count (4), direction codes, state encodings, win tile value (11).
REQ-028 One sub-module, lane_merge (combinational, 4 tiles in/out, changed flag, score increment under SCORE_EN), SHALL be instantiated exactly once.

Verification
REQ-029 Left, row0 = 1,1,2,2, rest 0 -> row0 = 2,3,0,0, moved=1, score_delta=12, done at T+6.
REQ-030 Right, row0 = 1,0,1,1 -> row0 = 0,0,1,2; three equal tiles merge trailing-pair per direction rule.
REQ-031 Up, column 0 = 3,3,3,3 -> 4,4,0,0, moved=1, score_delta=32.
REQ-032 Board with no legal left move (row0 = 1,2,3,4 each row) -> board_out=board_in, moved=0, score_delta=0.
REQ-033 Tile 15 pair merged -> 15 (saturate); req pulsed during LANE ignored; reset_n low mid-LANE -> IDLE, no done, board_out=0.

Source files
------------

// File: rtl/row_merge_sequencer_pkg.sv
// Shared types, constants and helpers for the row merge sequencer.
// Build option: define SCORE_EN to add the score_delta output.
package row_merge_sequencer_pkg;

  localparam int TILE_W   = 4;
  localparam int TILES    = 16;
  localparam int LANES    = 4;
  localparam int WIN_TILE = 11;
  localparam int SCORE_W  = 16;
  localparam int INC_W    = 18;

  typedef logic [TILE_W-1:0] tile_t;
  typedef tile_t [LANES-1:0] lane_t;
  typedef tile_t [TILES-1:0] board_t;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_UP    = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LOAD   = 2'b01,
    S_LANE   = 2'b10,
    S_FINISH = 2'b11
  } state_e;

  // Board tile number of slot p (0 = leading) in lane k.
  function automatic logic [3:0] tile_idx(
    input dir_e       d,
    input logic [1:0] k,
    input logic [1:0] p
  );
    logic [3:0] i;
    i = {k, p};
    unique case (d)
      DIR_LEFT:  i = {k, p};
      DIR_RIGHT: i = {k, ~p};
      DIR_UP:    i = {p, k};
      DIR_DOWN:  i = {~p, k};
      default:   i = {k, p};
    endcase
    return i;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] a,
    input logic [INC_W-1:0]   b
  );
    logic [INC_W:0] s;
    s = {3'b000, a} + {1'b0, b};
    if (s > (INC_W+1)'(17'h0FFFF)) begin
      return '1;
    end
    return s[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/row_merge_sequencer_lane_merge.sv
// Combinational slide-and-merge of one 4-tile lane, slot 0 leading.
// Build option: SCORE_EN adds the per-lane score increment output.
module lane_merge
  import row_merge_sequencer_pkg::*;
(
  input  logic [15:0] lane_i,
  output logic [15:0] lane_o,
  output logic        changed_o
`ifdef SCORE_EN
  ,
  output logic [INC_W-1:0] score_o
`endif
);

  lane_t      in_w;
  lane_t      out_w;
  tile_t      cmp [0:4];
  tile_t      res [0:3];
  logic [2:0] n;
  logic [1:0] j;
  logic       skip;
`ifdef SCORE_EN
  logic [INC_W-1:0] inc;
`endif

  assign in_w = lane_i;

  always_comb begin
    cmp  = '{default: '0};
    res  = '{default: '0};
    n    = '0;
    j    = '0;
    skip = 1'b0;
`ifdef SCORE_EN
    inc  = '0;
`endif
    for (int i = 0; i < 4; i++) begin
      if (in_w[i] != '0) begin
        cmp[n] = in_w[i];
        n      = n + 3'd1;
      end
    end
    // cmp[4] is always empty so slot 3 never pairs.
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else begin
        if (cmp[i] != '0 && cmp[i] == cmp[i+1]) begin
          res[j] = (cmp[i] == 4'hF) ? 4'hF : cmp[i] + 4'd1;
`ifdef SCORE_EN
          inc = inc + (INC_W'(1) << ({1'b0, cmp[i]} + 5'd1));
`endif
          skip = 1'b1;
        end else begin
          res[j] = cmp[i];
        end
        j = j + 2'd1;
      end
    end
    for (int p = 0; p < 4; p++) begin
      out_w[p] = res[p];
    end
  end

  assign lane_o    = out_w;
  assign changed_o = (out_w != in_w);
`ifdef SCORE_EN
  assign score_o   = inc;
`endif

endmodule

// File: rtl/row_merge_sequencer.sv
// Sequences a 4x4 tile-board move one lane per cycle through one merge unit.
// Build option: SCORE_EN adds score_delta.
module row_merge_sequencer
  import row_merge_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req,
  input  logic [1:0]  dir,
  input  logic [63:0] board_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] board_out,
  output logic        moved
`ifdef SCORE_EN
  ,
  output logic [15:0] score_delta
`endif
);

  state_e      state_q, state_d;
  logic [63:0] board_q, board_d;
  dir_e        dir_q, dir_d;
  logic [1:0]  lane_q, lane_d;
  board_t      result_q, result_d;
  logic        mv_acc_q, mv_acc_d;
  logic [63:0] bout_q, bout_d;
  logic        moved_q, moved_d;
  logic        done_q, done_d;
`ifdef SCORE_EN
  logic [SCORE_W-1:0] sc_acc_q, sc_acc_d;
  logic [SCORE_W-1:0] sc_q, sc_d;
  logic [INC_W-1:0]   lane_inc;
`endif

  logic [3:0] idx [LANES];
  lane_t      lane_in;
  lane_t      lane_out;
  logic       lane_chg;

  always_comb begin
    lane_in = '0;
    for (int p = 0; p < LANES; p++) begin
      idx[p]     = tile_idx(dir_q, lane_q, 2'(p));
      lane_in[p] = result_q[4'd15 - idx[p]];
    end
  end

  lane_merge u_merge (
    .lane_i    (lane_in),
    .lane_o    (lane_out),
    .changed_o (lane_chg)
`ifdef SCORE_EN
    ,
    .score_o   (lane_inc)
`endif
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (req) state_d = S_LOAD;
      S_LOAD:   state_d = S_LANE;
      S_LANE:   if (lane_q == 2'd3) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    board_d  = board_q;
    dir_d    = dir_q;
    lane_d   = lane_q;
    result_d = result_q;
    mv_acc_d = mv_acc_q;
    bout_d   = bout_q;
    moved_d  = moved_q;
    done_d   = 1'b0;
`ifdef SCORE_EN
    sc_acc_d = sc_acc_q;
    sc_d     = sc_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          board_d = board_in;
          dir_d   = dir_e'(dir);
        end
      end
      S_LOAD: begin
        lane_d   = '0;
        mv_acc_d = 1'b0;
        result_d = board_q;
`ifdef SCORE_EN
        sc_acc_d = '0;
`endif
      end
      S_LANE: begin
        for (int p = 0; p < LANES; p++) begin
          result_d[4'd15 - idx[p]] = lane_out[p];
        end
        lane_d   = lane_q + 2'd1;
        mv_acc_d = mv_acc_q | lane_chg;
`ifdef SCORE_EN
        sc_acc_d = sat_add(sc_acc_q, lane_inc);
`endif
        // Results land in the output registers as FINISH is entered.
        if (lane_q == 2'd3) begin
          bout_d  = result_d;
          moved_d = mv_acc_d;
          done_d  = 1'b1;
`ifdef SCORE_EN
          sc_d    = sc_acc_d;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      board_q  <= '0;
      dir_q    <= DIR_LEFT;
      lane_q   <= '0;
      result_q <= '0;
      mv_acc_q <= 1'b0;
      bout_q   <= '0;
      moved_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef SCORE_EN
      sc_acc_q <= '0;
      sc_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      dir_q    <= dir_d;
      lane_q   <= lane_d;
      result_q <= result_d;
      mv_acc_q <= mv_acc_d;
      bout_q   <= bout_d;
      moved_q  <= moved_d;
      done_q   <= done_d;
`ifdef SCORE_EN
      sc_acc_q <= sc_acc_d;
      sc_q     <= sc_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign board_out = bout_q;
  assign moved     = moved_q;
`ifdef SCORE_EN
  assign score_delta = sc_q;
`endif

endmodule
